// File: rtl/inst_fifo_pkg.sv
// Shared CPU fetch-bundle types and instruction-queue sizing for inst_fifo.
package inst_fifo_pkg;

   localparam int unsigned IFIFO_DEPTH = 8;
   localparam int unsigned IFIFO_SLOTS = 4;
   localparam int unsigned IFIFO_CNT_W = 4;
   localparam int unsigned IFIFO_PTR_W = 3;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
      logic [31:0] target_predict;
      logic        find_inst;
      logic        hit;
      logic        predict;
      logic        has_excp;
      logic [4:0]  excp_code;
   } fetch_slot_t;

   typedef struct packed {
      fetch_slot_t [IFIFO_SLOTS-1:0] slot;
   } fetch_bundle_t;

endpackage

// File: rtl/inst_fifo.sv
// Instruction FIFO between fetch and decode: 8 whole 4-slot bundles, flush clears, storage not reset.
// Optional macro IFIFO_BYPASS_EN: empty-queue bypass of the input bundle straight to decode.
module inst_fifo
   import inst_fifo_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             flush_ififo,
   input  logic             hint,
   input  logic [3:0][31:0] pc,
   input  logic [3:0][31:0] inst,
   input  logic [3:0][31:0] target_predict,
   input  logic [3:0]       find_inst,
   input  logic [3:0]       Hit,
   input  logic [3:0]       Predict,
   input  logic [3:0]       has_excp,
   input  logic [3:0][4:0]  excp_code,
   output logic             full_ififo,
   input  logic             stall_id,
   output logic             valid_out,
   output logic [3:0][31:0] pc_out,
   output logic [3:0][31:0] inst_out,
   output logic [3:0][31:0] target_predict_out,
   output logic [3:0]       find_inst_out,
   output logic [3:0]       Hit_out,
   output logic [3:0]       Predict_out,
   output logic [3:0]       has_excp_out,
   output logic [3:0][4:0]  excp_code_out
);

   logic [IFIFO_CNT_W-1:0] r_count;
   logic [IFIFO_PTR_W-1:0] r_rd_ptr;
   logic [IFIFO_PTR_W-1:0] r_wr_ptr;
   fetch_bundle_t          r_mem [IFIFO_DEPTH];

   fetch_bundle_t w_in;
   fetch_bundle_t w_head;
   logic          w_full;
   logic          w_nonempty;
   logic          w_bypass;
   logic          w_wr;
   logic          w_rd;

   always_comb begin
      w_in = '0;
      for (int unsigned k = 0; k < IFIFO_SLOTS; k++) begin
         w_in.slot[k].pc             = pc[k];
         w_in.slot[k].inst           = inst[k];
         w_in.slot[k].target_predict = target_predict[k];
         w_in.slot[k].find_inst      = find_inst[k];
         w_in.slot[k].hit            = Hit[k];
         w_in.slot[k].predict        = Predict[k];
         w_in.slot[k].has_excp       = has_excp[k];
         w_in.slot[k].excp_code      = excp_code[k];
      end
   end

   assign w_full     = (r_count == IFIFO_CNT_W'(IFIFO_DEPTH));
   assign w_nonempty = (r_count != '0);

`ifdef IFIFO_BYPASS_EN
   assign w_bypass = !w_nonempty && hint && !stall_id && !flush_ififo;
`else
   assign w_bypass = 1'b0;
`endif

   // A bypassed bundle is consumed by decode directly, so it is neither written nor popped.
   assign w_wr = hint && !w_full && !flush_ififo && !w_bypass;
   assign w_rd = w_nonempty && !stall_id && !flush_ififo;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_count  <= '0;
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
      end else if (flush_ififo) begin
         r_count  <= '0;
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
      end else begin
         if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
         if (w_wr && !w_rd)      r_count <= r_count + 1'b1;
         else if (!w_wr && w_rd) r_count <= r_count - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr) r_mem[r_wr_ptr] <= w_in;
   end

   assign w_head     = w_bypass ? w_in : r_mem[r_rd_ptr];
   assign full_ififo = w_full;
   assign valid_out  = w_nonempty || w_bypass;

   always_comb begin
      pc_out             = '0;
      inst_out           = '0;
      target_predict_out = '0;
      find_inst_out      = '0;
      Hit_out            = '0;
      Predict_out        = '0;
      has_excp_out       = '0;
      excp_code_out      = '0;
      for (int unsigned k = 0; k < IFIFO_SLOTS; k++) begin
         pc_out[k]             = w_head.slot[k].pc;
         inst_out[k]           = w_head.slot[k].inst;
         target_predict_out[k] = w_head.slot[k].target_predict;
         find_inst_out[k]      = w_head.slot[k].find_inst;
         Hit_out[k]            = w_head.slot[k].hit;
         Predict_out[k]        = w_head.slot[k].predict;
         has_excp_out[k]       = w_head.slot[k].has_excp;
         excp_code_out[k]      = w_head.slot[k].excp_code;
      end
   end

endmodule

// File: tb/tb_inst_fifo.sv
// Directed self-checking bench for inst_fifo; each bundle is derived from its slot-0 pc.
module tb_inst_fifo;

   logic             clk = 1'b0;
   logic             rst;
   logic             flush_ififo;
   logic             hint;
   logic [3:0][31:0] pc, inst, target_predict;
   logic [3:0]       find_inst, Hit, Predict, has_excp;
   logic [3:0][4:0]  excp_code;
   logic             full_ififo;
   logic             stall_id;
   logic             valid_out;
   logic [3:0][31:0] pc_out, inst_out, target_predict_out;
   logic [3:0]       find_inst_out, Hit_out, Predict_out, has_excp_out;
   logic [3:0][4:0]  excp_code_out;
   logic [419:0]     act;

   int n_cmp = 0;
   int n_err = 0;

   inst_fifo dut (
      .clk(clk), .rst(rst), .flush_ififo(flush_ififo), .hint,
      .pc(pc), .inst(inst), .target_predict(target_predict),
      .find_inst(find_inst), .Hit(Hit), .Predict(Predict),
      .has_excp(has_excp), .excp_code(excp_code),
      .full_ififo(full_ififo), .stall_id(stall_id), .valid_out(valid_out),
      .pc_out(pc_out), .inst_out(inst_out), .target_predict_out(target_predict_out),
      .find_inst_out(find_inst_out), .Hit_out(Hit_out), .Predict_out(Predict_out),
      .has_excp_out(has_excp_out), .excp_code_out(excp_code_out)
   );

   always #5 clk = ~clk;

   assign act = {pc_out, inst_out, target_predict_out, find_inst_out,
                 Hit_out, Predict_out, has_excp_out, excp_code_out};

   function automatic logic [419:0] exp_vec(input logic [31:0] b);
      logic [3:0][31:0] p, i, t;
      logic [3:0]       f, h, pr, e;
      logic [3:0][4:0]  c;
      for (int k = 0; k < 4; k++) begin
         p[k]  = b + 32'(4 * k);
         i[k]  = b ^ 32'hA5A5_0000 ^ 32'(k);
         t[k]  = b + 32'h200 + 32'(k);
         f[k]  = b[4+k];
         h[k]  = ~b[4+k];
         pr[k] = b[5] ^ k[0];
         e[k]  = (b[5:4] == 2'(k));
         c[k]  = b[8:4] + 5'(k);
      end
      return {p, i, t, f, h, pr, e, c};
   endfunction

   task automatic set_bundle(input logic [31:0] b);
      {pc, inst, target_predict, find_inst, Hit, Predict, has_excp, excp_code} = exp_vec(b);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0; flush_ififo = 1'b0; hint = 1'b0; stall_id = 1'b1;
      set_bundle(32'h0);
      #12;
      n_cmp++;
      if (valid_out !== 1'b0 || full_ififo !== 1'b0) begin
         n_err++;
         $display("FAIL reset_state: valid_out=%b full_ififo=%b, required 0 0", valid_out, full_ififo);
      end
      @(posedge clk); #1;
      rst = 1'b1;
      step();
      n_cmp++;
      if (valid_out !== 1'b0 || full_ififo !== 1'b0) begin
         n_err++;
         $display("FAIL post_reset_idle: valid_out=%b full_ififo=%b, required 0 0", valid_out, full_ififo);
      end
   endtask

   task automatic test_fill_drain();
      logic [31:0] b;
      stall_id = 1'b1;
      for (int i = 0; i < 8; i++) begin
         set_bundle(32'h1c00_0000 + 32'(i * 16));
         hint = 1'b1;
         step();
         n_cmp++;
         if (full_ififo !== (i == 7) || valid_out !== 1'b1) begin
            n_err++;
            $display("FAIL fill_%0d: full=%b valid=%b, required %b 1", i, full_ififo, valid_out, i == 7);
         end
      end
      set_bundle(32'h1c00_0080);
      step();
      hint = 1'b0;
      n_cmp++;
      if (full_ififo !== 1'b1) begin
         n_err++;
         $display("FAIL ninth_dropped_full: full=%b, required 1", full_ififo);
      end
      stall_id = 1'b0;
      for (int i = 0; i < 8; i++) begin
         b = 32'h1c00_0000 + 32'(i * 16);
         settle();
         n_cmp++;
         if (valid_out !== 1'b1 || act !== exp_vec(b)) begin
            n_err++;
            $display("FAIL drain_%0d: valid=%b pc0=%h, required 1 %h", i, valid_out, pc_out[0], b);
         end
         step();
      end
      n_cmp++;
      if (valid_out !== 1'b0 || full_ififo !== 1'b0) begin
         n_err++;
         $display("FAIL drain_empty: valid=%b full=%b pc0=%h, required 0 0", valid_out, full_ififo, pc_out[0]);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] b;
      stall_id = 1'b1;
      for (int i = 0; i < 3; i++) begin
         set_bundle(32'h1c00_1000 + 32'(i * 16));
         hint = 1'b1;
         step();
      end
      set_bundle(32'h1c00_1030);
      stall_id = 1'b0;
      settle();
      n_cmp++;
      if (valid_out !== 1'b1 || act !== exp_vec(32'h1c00_1000)) begin
         n_err++;
         $display("FAIL b2b_head: valid=%b pc0=%h, required 1 1c001000", valid_out, pc_out[0]);
      end
      step();
      hint = 1'b0;
      for (int i = 1; i < 4; i++) begin
         b = 32'h1c00_1000 + 32'(i * 16);
         settle();
         n_cmp++;
         if (valid_out !== 1'b1 || act !== exp_vec(b)) begin
            n_err++;
            $display("FAIL b2b_drain_%0d: valid=%b pc0=%h, required 1 %h", i, valid_out, pc_out[0], b);
         end
         step();
      end
      n_cmp++;
      if (valid_out !== 1'b0) begin
         n_err++;
         $display("FAIL b2b_count: valid=%b, required 0 (count must have stayed 3)", valid_out);
      end
   endtask

   task automatic test_full_deq();
      logic [31:0] b;
      stall_id = 1'b1;
      for (int i = 0; i < 8; i++) begin
         set_bundle(32'h1c00_2000 + 32'(i * 16));
         hint = 1'b1;
         step();
      end
      set_bundle(32'h1c00_2800);
      stall_id = 1'b0;
      step();
      hint = 1'b0;
      stall_id = 1'b1;
      settle();
      n_cmp++;
      if (full_ififo !== 1'b0 || valid_out !== 1'b1) begin
         n_err++;
         $display("FAIL full_deq_flags: full=%b valid=%b, required 0 1", full_ififo, valid_out);
      end
      stall_id = 1'b0;
      for (int i = 1; i < 8; i++) begin
         b = 32'h1c00_2000 + 32'(i * 16);
         settle();
         n_cmp++;
         if (valid_out !== 1'b1 || act !== exp_vec(b)) begin
            n_err++;
            $display("FAIL full_deq_drain_%0d: valid=%b pc0=%h, required 1 %h", i, valid_out, pc_out[0], b);
         end
         step();
      end
      n_cmp++;
      if (valid_out !== 1'b0) begin
         n_err++;
         $display("FAIL full_deq_blocked: valid=%b pc0=%h, required 0", valid_out, pc_out[0]);
      end
   endtask

   task automatic test_flush();
      stall_id = 1'b1;
      for (int i = 0; i < 5; i++) begin
         set_bundle(32'h1c00_3000 + 32'(i * 16));
         hint = 1'b1;
         step();
      end
      set_bundle(32'h1c00_3900);
      flush_ififo = 1'b1;
      step();
      flush_ififo = 1'b0;
      hint = 1'b0;
      n_cmp++;
      if (valid_out !== 1'b0 || full_ififo !== 1'b0) begin
         n_err++;
         $display("FAIL flush_clear: valid=%b full=%b, required 0 0", valid_out, full_ififo);
      end
      set_bundle(32'h1c00_3a00);
      hint = 1'b1;
      step();
      hint = 1'b0;
      stall_id = 1'b0;
      settle();
      n_cmp++;
      if (valid_out !== 1'b1 || act !== exp_vec(32'h1c00_3a00)) begin
         n_err++;
         $display("FAIL flush_refill: valid=%b pc0=%h, required 1 1c003a00", valid_out, pc_out[0]);
      end
      step();
      n_cmp++;
      if (valid_out !== 1'b0) begin
         n_err++;
         $display("FAIL flush_not_stored: valid=%b pc0=%h, required 0", valid_out, pc_out[0]);
      end
   endtask

   task automatic test_wrap_and_reset();
      logic [19:0] hint_pat  = 20'b1110_1111_1011_1101_1111;
      logic [19:0] stall_pat = 20'b0101_0011_0100_1100_0111;
      logic [31:0] q[$];
      logic [31:0] cur, want;
      logic        byp, deq, enq;
      int          cyc;
      for (int c = 0; c < 20; c++) begin
         cur = 32'h1c00_4000 + 32'(c * 16);
         set_bundle(cur);
         hint = hint_pat[c];
         stall_id = stall_pat[c];
         settle();
`ifdef IFIFO_BYPASS_EN
         byp = (q.size() == 0) && hint && !stall_id;
`else
         byp = 1'b0;
`endif
         want = byp ? cur : ((q.size() != 0) ? q[0] : 32'h0);
         n_cmp++;
         if (valid_out !== (q.size() != 0 || byp) ||
             ((q.size() != 0 || byp) && act !== exp_vec(want))) begin
            n_err++;
            $display("FAIL wrap_cycle_%0d: valid=%b pc0=%h, required %b %h",
                     c, valid_out, pc_out[0], (q.size() != 0 || byp), want);
         end
         deq = (q.size() != 0) && !stall_id;
         enq = hint && (q.size() < 8) && !byp;
         if (deq) void'(q.pop_front());
         if (enq) q.push_back(cur);
         step();
      end
      hint = 1'b0;
      stall_id = 1'b0;
      cyc = 0;
      while (q.size() != 0 && cyc < 10) begin
         settle();
         n_cmp++;
         if (valid_out !== 1'b1 || act !== exp_vec(q[0])) begin
            n_err++;
            $display("FAIL wrap_drain: valid=%b pc0=%h, required 1 %h", valid_out, pc_out[0], q[0]);
         end
         void'(q.pop_front());
         step();
         cyc++;
      end
      n_cmp++;
      if (valid_out !== 1'b0 || q.size() != 0) begin
         n_err++;
         $display("FAIL wrap_end: valid=%b left=%0d, required 0 0", valid_out, q.size());
      end
      stall_id = 1'b1;
      hint = 1'b1;
      set_bundle(32'h1c00_5000);
      step();
      step();
      hint = 1'b0;
      #2 rst = 1'b0;
      #1;
      n_cmp++;
      if (valid_out !== 1'b0 || full_ififo !== 1'b0) begin
         n_err++;
         $display("FAIL async_reset: valid=%b full=%b, required 0 0", valid_out, full_ififo);
      end
      step();
      rst = 1'b1;
      step();
      n_cmp++;
      if (valid_out !== 1'b0) begin
         n_err++;
         $display("FAIL async_reset_hold: valid=%b, required 0", valid_out);
      end
   endtask

   task automatic test_bypass();
      stall_id = 1'b0;
      set_bundle(32'h1c00_0040);
      hint = 1'b1;
      settle();
`ifdef IFIFO_BYPASS_EN
      n_cmp++;
      if (valid_out !== 1'b1 || act !== exp_vec(32'h1c00_0040)) begin
         n_err++;
         $display("FAIL bypass_same_cycle: valid=%b pc0=%h, required 1 1c000040", valid_out, pc_out[0]);
      end
      step();
      hint = 1'b0;
      settle();
      n_cmp++;
      if (valid_out !== 1'b0) begin
         n_err++;
         $display("FAIL bypass_not_written: valid=%b, required 0", valid_out);
      end
`else
      n_cmp++;
      if (valid_out !== 1'b0) begin
         n_err++;
         $display("FAIL latency_same_cycle: valid=%b, required 0", valid_out);
      end
      step();
      hint = 1'b0;
      settle();
      n_cmp++;
      if (valid_out !== 1'b1 || act !== exp_vec(32'h1c00_0040)) begin
         n_err++;
         $display("FAIL latency_next_cycle: valid=%b pc0=%h, required 1 1c000040", valid_out, pc_out[0]);
      end
      step();
      n_cmp++;
      if (valid_out !== 1'b0) begin
         n_err++;
         $display("FAIL latency_drained: valid=%b, required 0", valid_out);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_fill_drain();
      test_back_to_back();
      test_full_deq();
      test_flush();
      test_wrap_and_reset();
      test_bypass();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/inst_fifo.md
INST_FIFO -- requirements
Module: inst_fifo

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, all state on posedge.
REQ-002 SHALL have ports: rst  in  1  asynchronous active-low reset (rst==0 resets).
REQ-003 SHALL have ports: flush_ififo  in  1  pipeline flush (flush_back | Jump | Miss, combined upstream).
REQ-004 SHALL have ports: hint  in  1  fetch-register bundle valid (write request).
REQ-005 SHALL have ports: pc / inst / target_predict  in  32 x4  per-slot fetch data.
REQ-006 SHALL have ports: find_inst / Hit / Predict / has_excp  in  1 x4  per-slot flags; excp_code  in  5 x4.
REQ-007 SHALL have ports: full_ififo  out  1  queue full; upstream holds its bundle and locks the cache while high.
REQ-008 SHALL have ports: stall_id  in  1  decode not ready.
REQ-009 SHALL have ports: valid_out  out  1  head bundle valid toward decode.
REQ-010 SHALL have ports: pc_out, inst_out, target_predict_out, find_inst_out, Hit_out, Predict_out, has_excp_out, excp_code_out  out  widths as inputs, x4  head bundle.

Function
REQ-011 SHALL store whole 4-slot bundles; depth IFIFO_DEPTH = 8 entries; count width 4 bits, read/write pointers 3 bits, wrapping 7->0.
REQ-012 SHALL enqueue at posedge when hint==1 && full_ififo==0 && flush_ififo==0; otherwise the input bundle is ignored.
REQ-013 SHALL dequeue at posedge when valid_out==1 && stall_id==0 && flush_ififo==0.
REQ-014 SHALL drive full_ififo = (count==8) and valid_out = (count!=0), both decoded from registered count only.
REQ-015 SHALL present the head entry on *_out combinationally from storage; *_out contents are don't-care while valid_out==0.
REQ-016 SHALL keep count unchanged on simultaneous enqueue+dequeue; +1 on enqueue only; -1 on dequeue only.
REQ-017 SHALL block enqueue when full even if a dequeue occurs in the same cycle (full_ififo drops next cycle).
REQ-018 SHALL on flush_ififo==1 clear count and both pointers at that edge, with priority over any simultaneous enqueue or dequeue.
REQ-019 SHALL preserve strict FIFO order across pointer wrap-around.
REQ-020 SHALL store slots verbatim; slot validity (find_inst) is not filtered here.

Reset
REQ-021 SHALL on rst==0 immediately set count=0, rd_ptr=0, wr_ptr=0, hence full_ififo=0 and valid_out=0, including mid-operation.
REQ-022 SHALL NOT reset bundle storage; *_out are don't-care until the first enqueue.

Configuration
REQ-023 SHALL support macro IFIFO_BYPASS_EN.
REQ-024 With IFIFO_BYPASS_EN: when count==0, hint==1, stall_id==0, flush_ififo==0, the input bundle SHALL appear on *_out with valid_out==1 the same cycle and SHALL NOT be written (count stays 0).
REQ-025 Without IFIFO_BYPASS_EN: minimum latency hint->valid_out SHALL be one cycle; valid_out purely count-based.

Structure
REQ-026 SHALL take fetch_bundle_t (4 slots: pc, inst, target_predict, find_inst, Hit, Predict, has_excp, excp_code) and IFIFO_DEPTH from the shared CPU package.
REQ-027 SHALL be one module; no sub-module; storage is an array of fetch_bundle_t.

Verification
REQ-028 Reset, stall_id=1, 8 bundles pc0=0x1c000000 step 0x10 -> full_ififo=1 after 8th edge; 9th bundle (0x1c000080) dropped, count stays 8.
REQ-029 From REQ-028, stall_id=0 for 8 cycles -> pc_out[0] = 0x1c000000..0x1c000070 in order, then valid_out=0.
REQ-030 count=3, hint=1 and stall_id=0 same cycle -> count stays 3, head advances one entry.
REQ-031 count=5, flush_ififo=1 with hint=1 -> next cycle count=0, valid_out=0, full_ififo=0; flushed-cycle bundle not stored.
REQ-032 20 interleaved enqueue/dequeue with random stall_id across wrap -> output pc sequence equals input sequence; rst=0 mid-run -> valid_out=0 at once.
REQ-033 IFIFO_BYPASS_EN, empty, hint=1 pc[0]=0x1c000040, stall_id=0 -> valid_out=1, pc_out[0]=0x1c000040 same cycle, count=0 after edge; without macro -> valid_out=1 one cycle later.
